spi_adc_responder: RTL and testbench

SPI target that emulates a 2-channel, 10-bit MCP3002-style ADC. It answers the existing SPI ADC controller, either on a second board or inside a loopback bench. All pins are oversampled in the system clock domain. Channel values come from parallel inputs and are latched at the command sample point, then shifted out MSB-first, with an optional LSB-first tail.

---
 rtl/spi_adc_responder.sv | 176 +++++++++++++++++
 tb/tb_spi_adc_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder.sv
// Mode-0 SPI target emulating a 2-channel MCP3002-style ADC, pins oversampled on clk.
// pico_o/sample_o/frame_err_o react SYNC_STAGES+1 clk after the causing pin edge; no backpressure.
module spi_adc_responder #(
  parameter int DATA_WIDTH  = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_i,
  input  logic                  cs_i,
  input  logic                  copi_i,
  output logic                  pico_o,
  output logic                  pico_oe,
  input  logic [DATA_WIDTH-1:0] ch0_data,
  input  logic [DATA_WIDTH-1:0] ch1_data,
  output logic                  sample_o,
  output logic                  chan_o,
  output logic                  frame_err_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_MSB = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_LSB = CW'(DATA_WIDTH - 2);

  typedef enum logic [3:0] {
    IDLE, WAIT_START, GET_SGL, GET_ODD, GET_MSBF,
    NULL_BIT, DATA_MSB, DATA_LSB, DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, copi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;

  // Synchronisers reset to 0, so a CS held low through reset never looks like a fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      copi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_i};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, copi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  state_t                state_q, state_d;
  logic                  chan_q, chan_d;
  logic                  msbf_q, msbf_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic                  pico_q, pico_d;
  logic                  oe_q, oe_d;
  logic                  sample_q, sample_d;
  logic                  ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      chan_q   <= 1'b0;
      msbf_q   <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      pico_q   <= 1'b0;
      oe_q     <= 1'b0;
      sample_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      msbf_q   <= msbf_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      pico_q   <= pico_d;
      oe_q     <= oe_d;
      sample_q <= sample_d;
      ferr_q   <= ferr_d;
    end
  end

  logic [CW-1:0] msb_idx, lsb_idx;
  logic          in_frame;

  assign msb_idx  = LAST_MSB - bitcnt_q;
  assign lsb_idx  = bitcnt_q + CW'(1);
  assign in_frame = (state_q inside {GET_SGL, GET_ODD, GET_MSBF, NULL_BIT, DATA_MSB, DATA_LSB});

  // CS edges take priority; SCLK edges only count while synchronised CS is low.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    msbf_d   = msbf_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    pico_d   = pico_q;
    oe_d     = oe_q;
    sample_d = 1'b0;
    ferr_d   = 1'b0;
    if (cs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      pico_d  = 1'b0;
      ferr_d  = in_frame;
    end else if (cs_fall) begin
      if (state_q == IDLE) state_d = WAIT_START;
    end else if (!cs_s) begin
      case (state_q)
        WAIT_START: if (sclk_rise && copi_s) state_d = GET_SGL;
        GET_SGL:    if (sclk_rise) state_d = GET_ODD;
        GET_ODD: begin
          if (sclk_rise) begin
            chan_d  = copi_s;
            state_d = GET_MSBF;
          end
        end
        GET_MSBF: begin
          if (sclk_rise) begin
            msbf_d   = copi_s;
            shreg_d  = chan_q ? ch1_data : ch0_data;
            sample_d = 1'b1;
            state_d  = NULL_BIT;
          end
        end
        NULL_BIT: begin
          if (sclk_fall) begin
            oe_d     = 1'b1;
            pico_d   = 1'b0;
            bitcnt_d = '0;
            state_d  = DATA_MSB;
          end
        end
        DATA_MSB: begin
          if (sclk_fall) begin
            pico_d = shreg_q[msb_idx];
            if (bitcnt_q == LAST_MSB) begin
              bitcnt_d = '0;
              state_d  = msbf_q ? DONE : DATA_LSB;
            end else begin
              bitcnt_d = bitcnt_q + CW'(1);
            end
          end
        end
        DATA_LSB: begin
          if (sclk_fall) begin
            pico_d = shreg_q[lsb_idx];
            if (bitcnt_q == LAST_LSB) state_d = DONE;
            else bitcnt_d = bitcnt_q + CW'(1);
          end
        end
        DONE:    if (sclk_fall) pico_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign pico_o      = pico_q;
  assign pico_oe     = oe_q;
  assign sample_o    = sample_q;
  assign chan_o      = chan_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a mode-0 SPI controller model with an expected-bit scoreboard.
module tb_spi_adc_responder;
  localparam int DW = 10;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sclk = 1'b0;
  logic          cs = 1'b1;
  logic          copi = 1'b0;
  logic [DW-1:0] ch0 = '0;
  logic [DW-1:0] ch1 = '0;
  logic          pico, pico_oe, sample, chan, ferr;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  int   samp_cnt = 0;
  int   ferr_cnt = 0;
  int   ferr_wide = 0;
  logic ferr_prev = 1'b0;

  always #5 clk = ~clk;

  spi_adc_responder #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk), .cs_i(cs), .copi_i(copi),
    .pico_o(pico), .pico_oe(pico_oe), .ch0_data(ch0), .ch1_data(ch1),
    .sample_o(sample), .chan_o(chan), .frame_err_o(ferr)
  );

  always @(negedge clk) begin
    if (sample) samp_cnt++;
    if (ferr) begin
      ferr_cnt++;
      if (ferr_prev) ferr_wide++;
    end
    ferr_prev = ferr;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected controller view after MSBF: null bit, D9..D0, optional D1..D9 tail, then zeros.
  task automatic push_frame(input logic [DW-1:0] d, input bit msbf, input int n);
    bit b[$];
    b.push_back(1'b0);
    for (int i = DW - 1; i >= 0; i--) b.push_back(d[i]);
    if (!msbf) for (int i = 1; i < DW; i++) b.push_back(d[i]);
    while (b.size() < n) b.push_back(1'b0);
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
  endtask

  task automatic start_frame();
    cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // ncmd command bits then ndata clocks; pico is sampled on every post-command rise.
  task automatic shift(input string name, input logic [7:0] cmd, input int ncmd, input int ndata,
                       input bit chg, input logic [DW-1:0] chg_val);
    bit e;
    int seen;
    for (int i = 0; i < ncmd + ndata; i++) begin
      copi = (i < ncmd) ? cmd[ncmd-1-i] : 1'b0;
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      if (i >= ncmd) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s_scoreboard_empty bit %0d: got %b, nothing expected", name, i - ncmd, pico);
        end else begin
          e = exp_q.pop_front();
          if (pico !== e) begin
            fails++;
            $display("FAIL %s bit %0d: got %b expected %b", name, i - ncmd, pico, e);
          end
        end
      end
      seen = -1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (chg && i == ncmd - 1) begin
          if (seen >= 0) seen++;
          if (seen == 2) ch0 = chg_val;
          if (sample && seen < 0) seen = 0;
        end
      end
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    int oe_seen;
    int s0;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sclk = 1'($urandom); cs = 1'($urandom); copi = 1'($urandom);
      ch0 = DW'($urandom); ch1 = DW'($urandom);
    end
    #1;
    tests++; if (pico !== 1'b0)    begin fails++; $display("FAIL reset_pico: got %b expected 0", pico); end
    tests++; if (pico_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b expected 0", pico_oe); end
    tests++; if (sample !== 1'b0)  begin fails++; $display("FAIL reset_sample: got %b expected 0", sample); end
    tests++; if (chan !== 1'b0)    begin fails++; $display("FAIL reset_chan: got %b expected 0", chan); end
    tests++; if (ferr !== 1'b0)    begin fails++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    @(negedge clk);
    cs = 1'b0; sclk = 1'b0; copi = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    s0 = samp_cnt;
    oe_seen = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (i % 4 == 0) sclk = ~sclk;
      if (pico_oe) oe_seen++;
    end
    sclk = 1'b0;
    tests++; if (oe_seen != 0) begin fails++; $display("FAIL cs_low_at_release_oe: got %0d high cycles expected 0", oe_seen); end
    tests++; if (samp_cnt - s0 != 0) begin fails++; $display("FAIL cs_low_at_release_sample: got %0d pulses expected 0", samp_cnt - s0); end
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_ch0_msbf();
    int s0, f0;
    ch0 = 10'h2A5; ch1 = 10'h0F0;
    s0 = samp_cnt; f0 = ferr_cnt;
    push_frame(10'h2A5, 1'b1, 12);
    start_frame();
    shift("ch0_msbf", 8'b01101, 5, 12, 1'b0, '0);
    end_frame();
    tests++; if (samp_cnt - s0 != 1) begin fails++; $display("FAIL ch0_sample_count: got %0d expected 1", samp_cnt - s0); end
    tests++; if (chan !== 1'b0) begin fails++; $display("FAIL ch0_chan: got %b expected 0", chan); end
    tests++; if (ferr_cnt - f0 != 0) begin fails++; $display("FAIL ch0_frame_err: got %0d expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_ch1_lsb();
    int s0;
    ch0 = 10'h000; ch1 = 10'h3C1;
    s0 = samp_cnt;
    push_frame(10'h3C1, 1'b0, 22);
    start_frame();
    shift("ch1_lsb", 8'b1110, 4, 22, 1'b0, '0);
    end_frame();
    tests++; if (samp_cnt - s0 != 1) begin fails++; $display("FAIL ch1_sample_count: got %0d expected 1", samp_cnt - s0); end
    tests++; if (chan !== 1'b1) begin fails++; $display("FAIL ch1_chan: got %b expected 1", chan); end
  endtask

  task automatic test_latch_hold();
    ch0 = 10'h155; ch1 = 10'h000;
    push_frame(10'h155, 1'b1, 12);
    start_frame();
    shift("latch_hold", 8'b1101, 4, 12, 1'b1, 10'h2AA);
    end_frame();
    tests++; if (chan !== 1'b0) begin fails++; $display("FAIL latch_chan: got %b expected 0", chan); end
  endtask

  task automatic test_abort();
    int f0, w0;
    ch0 = 10'h2A5;
    push_frame(10'h2A5, 1'b1, 5);
    start_frame();
    shift("abort", 8'b1101, 4, 5, 1'b0, '0);
    repeat (8) @(negedge clk);
    tests++; if (pico_oe !== 1'b1) begin fails++; $display("FAIL abort_oe_before: got %b expected 1", pico_oe); end
    f0 = ferr_cnt; w0 = ferr_wide;
    cs = 1'b1;
    repeat (SS + 1) @(negedge clk);
    tests++; if (pico_oe !== 1'b0) begin fails++; $display("FAIL abort_oe_after: got %b expected 0", pico_oe); end
    repeat (10) @(negedge clk);
    tests++; if (ferr_cnt - f0 != 1) begin fails++; $display("FAIL abort_err_count: got %0d expected 1", ferr_cnt - f0); end
    tests++; if (ferr_wide - w0 != 0) begin fails++; $display("FAIL abort_err_width: got %0d extra cycles expected 0", ferr_wide - w0); end
    ch0 = 10'h001;
    f0 = ferr_cnt;
    push_frame(10'h001, 1'b1, 12);
    start_frame();
    shift("after_abort", 8'b1101, 4, 12, 1'b0, '0);
    end_frame();
    tests++; if (ferr_cnt - f0 != 0) begin fails++; $display("FAIL after_abort_err: got %0d expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_async_reset();
    int f0;
    ch0 = 10'h000; ch1 = 10'h2A5;
    push_frame(10'h2A5, 1'b1, 4);
    start_frame();
    shift("pre_reset", 8'b1111, 4, 4, 1'b0, '0);
    repeat (4) @(negedge clk);
    tests++; if (pico_oe !== 1'b1) begin fails++; $display("FAIL pre_reset_oe: got %b expected 1", pico_oe); end
    tests++; if (chan !== 1'b1)    begin fails++; $display("FAIL pre_reset_chan: got %b expected 1", chan); end
    f0 = ferr_cnt;
    rst = 1'b0;
    #1;
    tests++; if (pico_oe !== 1'b0) begin fails++; $display("FAIL async_reset_oe: got %b expected 0", pico_oe); end
    tests++; if (chan !== 1'b0)    begin fails++; $display("FAIL async_reset_chan: got %b expected 0", chan); end
    tests++; if (pico !== 1'b0)    begin fails++; $display("FAIL async_reset_pico: got %b expected 0", pico); end
    repeat (3) @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    ch0 = 10'h3C1;
    push_frame(10'h3C1, 1'b1, 12);
    start_frame();
    shift("post_reset", 8'b1101, 4, 12, 1'b0, '0);
    end_frame();
    tests++; if (ferr_cnt - f0 != 0) begin fails++; $display("FAIL post_reset_err: got %0d expected 0", ferr_cnt - f0); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_ch0_msbf();
    test_ch1_lsb();
    test_latch_hold();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
